// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one memory request per
// instruction and parks the returned word in a one-entry slot for decode.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_addr,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata,
   output logic        o_inst_valid,
   input  logic        i_inst_ready,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_fault
);

   // state | meaning
   // IDLE  | first cycle out of reset, no request
   // REQ   | issue at pc whenever the slot is free or draining
   // WAIT  | committed request outstanding, address held
   // DROP  | request outstanding whose data is stale, discarded on completion
   // FAULT | memory timed out, only reset leaves
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DROP,
      ST_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_drop_addr;
   logic [31:0]      r_inst;
   logic [31:0]      r_inst_pc;
   logic             r_inst_valid;
   logic             r_fault;
   logic [CNT_W-1:0] r_wait_cnt;

   logic             w_issue;
   logic             w_mem_req;
   logic [31:0]      w_target;
   logic [31:0]      w_pc_next;
   logic             w_timeout;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_issue   = (r_state == ST_REQ) && (!r_inst_valid || i_inst_ready);
   assign w_mem_req = w_issue || (r_state == ST_WAIT) || (r_state == ST_DROP);
   assign w_target  = i_redirect_addr & ~32'h0000_0003;
   assign w_pc_next = r_pc + 32'd4;
   assign w_timeout = (r_wait_cnt >= TC_LAST);
   assign w_cnt_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

   // A stale request keeps its original address while the PC moves on.
   assign o_mem_req    = w_mem_req;
   assign o_mem_addr   = (r_state == ST_DROP) ? r_drop_addr : r_pc;
   assign o_inst_valid = r_inst_valid;
   assign o_inst       = r_inst;
   assign o_inst_pc    = r_inst_pc;
   assign o_fault      = r_fault;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_drop_addr  <= RESET_PC;
         r_inst       <= 32'h0;
         r_inst_pc    <= 32'h0;
         r_inst_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_wait_cnt   <= '0;
      end else begin
         if (r_inst_valid && i_inst_ready)
            r_inst_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_state <= ST_REQ;
               if (i_redirect)
                  r_pc <= w_target;
            end

            ST_REQ: begin
               if (i_redirect) begin
                  r_pc         <= w_target;
                  r_inst_valid <= 1'b0;
                  if (w_issue && !i_mem_ready) begin
                     r_drop_addr <= r_pc;
                     r_state     <= ST_DROP;
                  end
               end else if (w_issue) begin
                  if (i_mem_ready) begin
                     r_inst       <= i_mem_rdata;
                     r_inst_pc    <= r_pc;
                     r_inst_valid <= 1'b1;
                     r_pc         <= w_pc_next;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               if (i_mem_ready) begin
                  r_wait_cnt <= '0;
                  r_state    <= ST_REQ;
                  if (i_redirect) begin
                     r_pc         <= w_target;
                     r_inst_valid <= 1'b0;
                  end else begin
                     r_inst       <= i_mem_rdata;
                     r_inst_pc    <= r_pc;
                     r_inst_valid <= 1'b1;
                     r_pc         <= w_pc_next;
                  end
               end else if (i_redirect) begin
                  r_pc         <= w_target;
                  r_inst_valid <= 1'b0;
                  r_drop_addr  <= r_pc;
                  r_wait_cnt   <= w_cnt_inc;
                  r_state      <= ST_DROP;
               end else if (w_timeout) begin
                  r_wait_cnt   <= w_cnt_inc;
                  r_inst_valid <= 1'b0;
                  r_fault      <= 1'b1;
                  r_state      <= ST_FAULT;
               end else begin
                  r_wait_cnt <= w_cnt_inc;
               end
            end

            ST_DROP: begin
               if (i_mem_ready) begin
                  r_wait_cnt <= '0;
                  r_state    <= ST_REQ;
                  if (i_redirect) begin
                     r_pc         <= w_target;
                     r_inst_valid <= 1'b0;
                  end
               end else if (i_redirect) begin
                  r_pc         <= w_target;
                  r_inst_valid <= 1'b0;
                  r_wait_cnt   <= w_cnt_inc;
               end else if (w_timeout) begin
                  r_wait_cnt   <= w_cnt_inc;
                  r_inst_valid <= 1'b0;
                  r_fault      <= 1'b1;
                  r_state      <= ST_FAULT;
               end else begin
                  r_wait_cnt <= w_cnt_inc;
               end
            end

            ST_FAULT: begin
               r_inst_valid <= 1'b0;
               r_fault      <= 1'b1;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
